alu_byte_seq: RTL
=================

ALU_BYTE_SEQ -- requirements
Module: alu_byte_seq

Interface
- REQ-001 Parameter NBYTES, default 4, operand width in bytes (legal 2..8).
- REQ-002 clk  in  1  sole clock; all state updates on rising edge.
- REQ-003 rst  in  1  synchronous, active-high reset.
- REQ-004 req_valid  in  1  request offered.
- REQ-005 req_ready  out  1  request accepted on clk edge when valid&&ready.
- REQ-006 req_mode  in  1  ALU mode bit, held for whole operation.
- REQ-007 req_sel  in  4  ALU selector, held for whole operation.
- REQ-008 req_a, req_b  in  8*NBYTES  operands; byte 0 = bits [7:0].
- REQ-009 req_cin  in  1  carry into byte 0.
- REQ-010 alu_mode, alu_sel, alu_a, alu_b, alu_cin  out  1/4/8/8/1  drive the 8-bit ALU.
- REQ-011 alu_f, alu_cout  in  8/1  combinational ALU result for the driven byte; ALU zero flag not used.
- REQ-012 rsp_valid  out  1  result available.
- REQ-013 rsp_ready  in  1  consumer accepts on clk edge when valid&&ready.
- REQ-014 rsp_f  out  8*NBYTES  assembled result.
- REQ-015 rsp_cout, rsp_zero  out  1/1  final carry; whole-result zero.

Function
- REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
- REQ-017 IDLE: req_ready=1; on req_valid, latch mode, sel, a, b, cin; byte index=0; go RUN.
- REQ-018 RUN/DONE: req_ready=0; request inputs ignored after acceptance.
- REQ-019 RUN, byte index i: alu_a/alu_b = latched byte i, alu_mode/alu_sel = latched values, alu_cin = req_cin if i=0, else alu_cout captured at byte i-1.
- REQ-020 RUN, each edge: alu_f -> rsp_f byte i; alu_cout -> carry register; i increments.
- REQ-021 After byte NBYTES-1 captured: go DONE; rsp_cout = that byte's alu_cout; rsp_zero=1 iff all 8*NBYTES result bits zero.
- REQ-022 Latency: acceptance at edge T -> rsp_valid high after edge T+NBYTES; one op per NBYTES+2 cycles minimum.
- REQ-023 DONE: rsp_valid=1; rsp_f/rsp_cout/rsp_zero stable while rsp_ready=0.
- REQ-024 DONE with rsp_ready=1: return to IDLE; no new request accepted on that same edge.
- REQ-025 Carry chaining applies in both modes; in mode 1 rsp_cout is final-byte alu_cout, no interpretation.
- REQ-026 Outside RUN: alu_a, alu_b, alu_cin = 0; alu_mode, alu_sel hold last latched values.

Reset
- REQ-027 rst over-rides everything: state IDLE, rsp_valid=0, rsp_f=0, rsp_cout=0, rsp_zero=0, byte index 0, carry 0, latched operands 0.
- REQ-028 rst during RUN or DONE aborts; partial/pending result is discarded, no response issued.
- REQ-029 req_ready=1 in the first cycle after reset deasserts.

Structure
- REQ-030 Package alu_byte_seq_pkg holds the state enum (IDLE, RUN, DONE) and the NBYTES default constant.
- REQ-031 One sub-module alu_byte_shreg: NBYTES-deep byte shift register presenting byte i of A/B and collecting result bytes; FSM, carry register and zero reduction stay in alu_byte_seq.
- REQ-032 ALU instantiated outside this block and connected at the parent level.

Verification
Bench ALU model: mode 0 / sel 4'h9 -> F = A+B+cin, cout = carry-out; mode 1 / sel 4'h6 -> F = A^B, cout=0.
- REQ-033 Add, a=0x00FFFFFF, b=0x00000001, cin=0 -> rsp_f=0x01000000, rsp_cout=0, rsp_zero=0; rsp_valid exactly 4 edges after acceptance.
- REQ-034 Add, a=0xFFFFFFFF, b=0x00000001, cin=0 -> alu_cin=1 on bytes 1..3; rsp_f=0, rsp_cout=1, rsp_zero=1.
- REQ-035 XOR, a=b=0xA5A5A5A5 -> rsp_f=0, rsp_zero=1; a=0x12345678, b=0 -> rsp_f=0x12345678, rsp_zero=0.
- REQ-036 Backpressure: rsp_ready=0 for 5 cycles in DONE -> outputs stable, req_ready=0 throughout; release -> IDLE, next request accepted one edge later.
- REQ-037 Reset mid-RUN (after byte 1) -> next cycle rsp_valid=0, req_ready=1; following add 0x00000001+0x00000001 returns 0x00000002, cout=0.
- REQ-038 Request operands changed on every cycle after acceptance -> result reflects only the accepted values.

Source files
------------

// File: rtl/alu_byte_seq_pkg.sv
// Shared types and constants for the byte-serial ALU sequencer.
package alu_byte_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NBYTES_DEFAULT = 4;

endpackage

// File: rtl/alu_byte_shreg.sv
// Operand/result byte shift register: presents byte i of A/B and assembles the
// result by shifting each new ALU byte in at the top.
module alu_byte_shreg
  import alu_byte_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  input  logic [7:0]            f_in,
  output logic [7:0]            a_byte,
  output logic [7:0]            b_byte,
  output logic [8*NBYTES-1:0]   res,
  output logic [8*NBYTES-1:0]   res_nxt
);

  localparam int W = 8 * NBYTES;

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] res_q, res_d;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_nxt = {f_in, res_q[W-1:8]};
    res_d   = res_q;
    if (load) begin
      a_d = a_in;
      b_d = b_in;
    end else if (shift) begin
      a_d   = {8'h00, a_q[W-1:8]};
      b_d   = {8'h00, b_q[W-1:8]};
      res_d = res_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

  assign a_byte = a_q[7:0];
  assign b_byte = b_q[7:0];
  assign res    = res_q;

endmodule

// File: rtl/alu_byte_seq.sv
// Sequences an external 8-bit ALU over NBYTES operand bytes, LSB first,
// chaining the carry between bytes and returning the assembled result.
module alu_byte_seq
  import alu_byte_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [3:0]            req_sel,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic                  req_cin,
  output logic                  alu_mode,
  output logic [3:0]            alu_sel,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cin,
  input  logic [7:0]            alu_f,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_f,
  output logic                  rsp_cout,
  output logic                  rsp_zero
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           mode_q, mode_d;
  logic [3:0]     sel_q, sel_d;
  logic           cin_q, cin_d;
  logic           zero_q, zero_d;
  logic           load, shift;
  logic [7:0]     a_byte, b_byte;
  logic [8*NBYTES-1:0] res_nxt;

  alu_byte_shreg #(.NBYTES(NBYTES)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .a_in    (req_a),
    .b_in    (req_b),
    .f_in    (alu_f),
    .a_byte  (a_byte),
    .b_byte  (b_byte),
    .res     (rsp_f),
    .res_nxt (res_nxt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    cin_d   = cin_q;
    zero_d  = zero_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          load    = 1'b1;
          mode_d  = req_mode;
          sel_d   = req_sel;
          cin_d   = req_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        shift   = 1'b1;
        carry_d = alu_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // res_nxt is the full result once the final byte lands
          zero_d  = ~|res_nxt;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      sel_q   <= 4'h0;
      cin_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      cin_q   <= cin_d;
      zero_q  <= zero_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_cout  = carry_q;
  assign rsp_zero  = zero_q;

  assign alu_mode  = mode_q;
  assign alu_sel   = sel_q;
  assign alu_a     = (state_q == RUN) ? a_byte : 8'h00;
  assign alu_b     = (state_q == RUN) ? b_byte : 8'h00;
  assign alu_cin   = (state_q == RUN) ? ((idx_q == '0) ? cin_q : carry_q) : 1'b0;

endmodule
